reg_storage_bank: RTL and testbench

- Sequential storage array for the register file; sits directly upstream of the read-port mux tree built from 4:1 and 2:1 muxes.
- Holds NREGS registers of WIDTH bits and accepts one write per clock through a decoded write enable.
- Exposes every register's contents on a flattened bus, which the downstream read muxes select from.
- Also tracks a per-register "written since reset/clear" valid mask, used by hazard and debug logic.

---
 rtl/reg_storage_bank.sv | 78 +++++++
 tb/tb_reg_storage_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_storage_bank.sv
// Register-file storage array: NREGS x WIDTH flops, one decoded write per clock, with a per-register valid mask.
// Optional macro REG_STORAGE_ZERO_REG_EN hardwires register NREGS-1 to zero and marks it valid.
module reg_storage_bank #(
  parameter int WIDTH  = 64,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clear,
  output logic [NREGS*WIDTH-1:0] regs_out,
  output logic [NREGS-1:0]       reg_valid,
  output logic                   wr_ack,
  output logic                   wr_err
);

`ifdef REG_STORAGE_ZERO_REG_EN
  localparam int NSTORE = NREGS - 1;
`else
  localparam int NSTORE = NREGS;
`endif

  logic              in_range;
  logic [NSTORE-1:0] wr_sel;

  assign in_range = ({{(32-ADDR_W){1'b0}}, wr_addr} < 32'(NREGS));

  // One-hot write decode; clear suppresses every load so it wins over a same-edge write.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NSTORE; i++) begin
      if (wr_en && !clear && (wr_addr == ADDR_W'(i))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NSTORE; g++) begin : g_reg
    logic [WIDTH-1:0] q;
    logic             v;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q <= '0;
        v <= 1'b0;
      end else if (clear) begin
        q <= '0;
        v <= 1'b0;
      end else if (wr_sel[g]) begin
        q <= wr_data;
        v <= 1'b1;
      end
    end

    assign regs_out[g*WIDTH +: WIDTH] = q;
    assign reg_valid[g]               = v;
  end

`ifdef REG_STORAGE_ZERO_REG_EN
  // Top register is a constant zero source; writes to it are acknowledged but ignored.
  assign regs_out[(NREGS-1)*WIDTH +: WIDTH] = '0;
  assign reg_valid[NREGS-1]                 = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_en & in_range & ~clear;
      wr_err <= wr_en & ~in_range & ~clear;
    end
  end

endmodule

// File: tb/tb_reg_storage_bank.sv
// Directed bench for reg_storage_bank: a 32-entry instance and a 20-entry instance share the write inputs.
module tb_reg_storage_bank;
  localparam int W  = 64;
  localparam int NA = 32;
  localparam int NB = 20;

`ifdef REG_STORAGE_ZERO_REG_EN
  localparam logic [NA-1:0] VBASE_A = 32'h8000_0000;
  localparam logic [NB-1:0] VBASE_B = 20'h8_0000;
  localparam logic [W-1:0]  TOP_A   = 64'h0;
`else
  localparam logic [NA-1:0] VBASE_A = '0;
  localparam logic [NB-1:0] VBASE_B = '0;
  localparam logic [W-1:0]  TOP_A   = 64'h1F1F;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [W-1:0]    wr_data;
  logic            clear;
  logic [NA*W-1:0] regs_a;
  logic [NA-1:0]   valid_a;
  logic            ack_a, err_a;
  logic [NB*W-1:0] regs_b;
  logic [NB-1:0]   valid_b;
  logic            ack_b, err_b;

  logic [NA*W-1:0] ea;
  logic [NB*W-1:0] eb;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_storage_bank #(.WIDTH(W), .NREGS(NA), .ADDR_W(5)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .regs_out(regs_a), .reg_valid(valid_a), .wr_ack(ack_a), .wr_err(err_a)
  );

  reg_storage_bank #(.WIDTH(W), .NREGS(NB), .ADDR_W(5)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .regs_out(regs_b), .reg_valid(valid_b), .wr_ack(ack_b), .wr_err(err_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en = 1'b0; clear = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic do_clear;
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle();
    tick(); tick();
    tests++; if (regs_a !== '0) begin fails++; $display("FAIL reset_regs got=%h want=0", regs_a[0 +: W]); end
    tests++; if (valid_a !== VBASE_A) begin fails++; $display("FAIL reset_valid got=%h want=%h", valid_a, VBASE_A); end
    tests++; if (ack_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL reset_flags ack=%b err=%b want 0 0", ack_a, err_a); end
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h55;
    tick();
    wr_en = 1'b0;
    tests++; if (regs_a[2*W +: W] !== 64'h55 || ack_a !== 1'b1) begin fails++; $display("FAIL prewrite slice2=%h ack=%b want 55 1", regs_a[2*W +: W], ack_a); end
    #2 reset = 1'b1;
    #1;
    tests++; if (regs_a !== '0) begin fails++; $display("FAIL async_reset_regs slice2=%h want=0", regs_a[2*W +: W]); end
    tests++; if (valid_a !== VBASE_A || ack_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL async_reset_ctrl valid=%h ack=%b err=%b want %h 0 0", valid_a, ack_a, err_a, VBASE_A); end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h99;
    tick();
    tests++; if (regs_a[6*W +: W] !== '0 || ack_a !== 1'b0) begin fails++; $display("FAIL write_during_reset slice6=%h ack=%b want 0 0", regs_a[6*W +: W], ack_a); end
    reset = 1'b0;
    wr_addr = 5'd1; wr_data = 64'h11;
    tick();
    idle();
    tests++; if (regs_a[1*W +: W] !== 64'h11 || ack_a !== 1'b1) begin fails++; $display("FAIL first_write_after_reset slice1=%h ack=%b want 11 1", regs_a[1*W +: W], ack_a); end
  endtask

  task automatic test_single_write;
    do_clear();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    idle();
    ea = '0; ea[5*W +: W] = 64'hDEAD_BEEF_0123_4567;
    tests++; if (regs_a !== ea) begin fails++; $display("FAIL single_regs slice5=%h want=%h", regs_a[5*W +: W], ea[5*W +: W]); end
    tests++; if (valid_a !== (VBASE_A | 32'h0000_0020)) begin fails++; $display("FAIL single_valid got=%h want=%h", valid_a, VBASE_A | 32'h20); end
    tests++; if (ack_a !== 1'b1 || err_a !== 1'b0) begin fails++; $display("FAIL single_ack ack=%b err=%b want 1 0", ack_a, err_a); end
    tick();
    tests++; if (ack_a !== 1'b0) begin fails++; $display("FAIL single_ack_drop ack=%b want 0", ack_a); end
    tests++; if (regs_a !== ea) begin fails++; $display("FAIL single_hold slice5=%h want=%h", regs_a[5*W +: W], ea[5*W +: W]); end
  endtask

  task automatic test_all_regs;
    int ack_bad;
    do_clear();
    ack_bad = 0;
    for (int i = 0; i < NA; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'(i) * 64'h0101;
      tick();
      if (ack_a !== 1'b1) ack_bad++;
    end
    idle();
    tests++; if (ack_bad != 0) begin fails++; $display("FAIL all_acks missing=%0d want=0", ack_bad); end
    for (int i = 0; i < NA - 1; i++) ea[i*W +: W] = 64'(i) * 64'h0101;
    ea[31*W +: W] = TOP_A;
    for (int i = 0; i < NA; i++) begin
      tests++;
      if (regs_a[i*W +: W] !== ea[i*W +: W]) begin
        fails++; $display("FAIL all_slice%0d got=%h want=%h", i, regs_a[i*W +: W], ea[i*W +: W]);
      end
    end
    tests++; if (valid_a !== 32'hFFFF_FFFF) begin fails++; $display("FAIL all_valid got=%h want=ffffffff", valid_a); end
  endtask

  task automatic test_clear_write;
    clear = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234;
    tick();
    idle();
    tests++; if (regs_a !== '0) begin fails++; $display("FAIL clear_regs slice3=%h slice30=%h want 0", regs_a[3*W +: W], regs_a[30*W +: W]); end
    tests++; if (valid_a !== VBASE_A) begin fails++; $display("FAIL clear_valid got=%h want=%h", valid_a, VBASE_A); end
    tests++; if (ack_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL clear_flags ack=%b err=%b want 0 0", ack_a, err_a); end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234;
    tick();
    idle();
    tests++; if (regs_a[3*W +: W] !== 64'h1234 || ack_a !== 1'b1) begin fails++; $display("FAIL clear_then_write slice3=%h ack=%b want 1234 1", regs_a[3*W +: W], ack_a); end
  endtask

  task automatic test_out_of_range;
    do_clear();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h44;
    tick();
    tests++; if (ack_b !== 1'b1 || err_b !== 1'b0) begin fails++; $display("FAIL oor_prewrite ack=%b err=%b want 1 0", ack_b, err_b); end
    wr_addr = 5'd25; wr_data = 64'hFF;
    tick();
    idle();
    eb = '0; eb[4*W +: W] = 64'h44;
    tests++; if (regs_b !== eb) begin fails++; $display("FAIL oor_regs slice4=%h want=44", regs_b[4*W +: W]); end
    tests++; if (valid_b !== (VBASE_B | 20'h10)) begin fails++; $display("FAIL oor_valid got=%h want=%h", valid_b, VBASE_B | 20'h10); end
    tests++; if (err_b !== 1'b1 || ack_b !== 1'b0) begin fails++; $display("FAIL oor_pulse err=%b ack=%b want 1 0", err_b, ack_b); end
    tick();
    tests++; if (err_b !== 1'b0 || ack_b !== 1'b0) begin fails++; $display("FAIL oor_pulse_end err=%b ack=%b want 0 0", err_b, ack_b); end
    tests++; if (regs_b !== eb) begin fails++; $display("FAIL oor_hold slice4=%h want=44", regs_b[4*W +: W]); end
  endtask

  task automatic test_back_to_back;
    do_clear();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hA;
    tick();
    tests++; if (regs_a[7*W +: W] !== 64'hA || ack_a !== 1'b1) begin fails++; $display("FAIL b2b_first slice7=%h ack=%b want a 1", regs_a[7*W +: W], ack_a); end
    wr_data = 64'hB;
    tick();
    idle();
    tests++; if (regs_a[7*W +: W] !== 64'hB || ack_a !== 1'b1) begin fails++; $display("FAIL b2b_second slice7=%h ack=%b want b 1", regs_a[7*W +: W], ack_a); end
    tests++; if (valid_a !== (VBASE_A | 32'h80)) begin fails++; $display("FAIL b2b_valid got=%h want=%h", valid_a, VBASE_A | 32'h80); end
  endtask

  task automatic test_hold;
    wr_en = 1'b0; wr_addr = 5'd7; wr_data = 64'hCC;
    tick();
    idle();
    tests++; if (regs_a[7*W +: W] !== 64'hB || ack_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL hold slice7=%h ack=%b err=%b want b 0 0", regs_a[7*W +: W], ack_a, err_a); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_all_regs();
    test_clear_write();
    test_out_of_range();
    test_back_to_back();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
